i2s_rx_deserializer: RTL and testbench
======================================

Name: i2s_rx_deserializer

Overview:
Record-path counterpart of the codec playback serializer. It deserializes the codec ADC I2S stream (ac_recdat, framed by ac_reclrc and ac_bclk) into parallel stereo words. It presents each complete left/right frame on a valid/ready interface in the codec-unit clock domain, where the AXI-side record FIFO picks it up. Sticky status flags report overrun and short words to the register block.

Parameters:
DATA_WIDTH, 24, bits captured per channel; MSB-first; must be 16..32
SLOT_BITS, 32, maximum bclk periods per half-frame; extra bits ignored
SYNC_STAGES, 2, synchronizer depth on i2s_bclk/i2s_lrclk/i2s_sdata

Ports:
board_clk  in  1  block clock; must be at least 8x the i2s_bclk frequency
board_aresetn  in  1  asynchronous active-low reset
rx_en  in  1  receiver enable, level
i2s_bclk  in  1  codec bit clock (ac_bclk)
i2s_lrclk  in  1  record word select (ac_reclrc); 0 = left, 1 = right
i2s_sdata  in  1  record serial data (ac_recdat)
sample_data  out  2*DATA_WIDTH  {left, right}; left in the upper half
sample_valid  out  1  sample_data holds an unconsumed frame
sample_ready  in  1  consumer accepts the frame
rx_locked  out  1  high in LEFT/RIGHT states
overrun  out  1  sticky: a completed frame was dropped
short_word  out  1  sticky: a half-frame ended with fewer than DATA_WIDTH bits
status_clr  in  1  one-cycle pulse; clears overrun and short_word

Behaviour:
- Reset (async assert, sync release): all outputs 0, sample_data 0, state IDLE, bit counter 0, shift registers 0.
- i2s_bclk, i2s_lrclk and i2s_sdata pass through identical SYNC_STAGES flop chains, so they stay mutually aligned.
- A bclk rising edge (rise) is a 1-cycle pulse, registered, when the synchronized bclk was 0 in the previous cycle and is 1 now. All sampling happens on rise cycles only.
- On each rise, sample lr_now and bit. lr_prev holds lr_now from the previous rise.
- A transition is a rise where lr_now != lr_prev.
- I2S framing, 1-bit delay: at a transition, the sampled bit is still the last bit of the old word. The MSB of the new word arrives on the next rise.
- Bit counter: 6 bits, saturates at SLOT_BITS.
  - On a non-transition rise: if count < DATA_WIDTH, shift the bit into the current channel register at position DATA_WIDTH-1-count. Increment count (saturating).
  - On a transition: capture the bit under the same rule, close the word, then reset count to 0.
- If a word closes with count after capture < DATA_WIDTH, the low bits stay 0 (zero-padded) and short_word is set. The word is still delivered.
- FSM:
  - IDLE: if rx_en, go to SYNC.
  - SYNC: discard data; on a transition with lr_now = 0 (start of a left word), go to LEFT with count 0.
  - LEFT: on a transition with lr_now = 1, latch the left word and go to RIGHT.
  - RIGHT: on a transition with lr_now = 0, latch the right word, raise frame_done for one cycle, and go to LEFT.
  - Any state: if rx_en = 0, go to IDLE next cycle. A partial frame is discarded; a pending output is kept until accepted.
- Output register: sample_valid rises the cycle after frame_done, i.e. one board_clk cycle after the registered rise pulse for the closing transition.
  - Handshake completes when valid && ready, and valid drops next cycle.
  - sample_data is stable while valid && !ready.
  - If frame_done occurs while valid && !ready: drop the new frame, keep the old one, set overrun.
  - If frame_done and (valid && ready) occur in the same cycle: load the new frame and keep valid high. This is not an overrun.
- status_clr takes priority over a simultaneous set. The flag is cleared that cycle and the set event is lost.
- Arithmetic: counter compare is unsigned; no wrap, since it saturates.

Decomposition:
- codec_pkg (shared):
  - i2s_rx_state_t enum {IDLE, SYNC, LEFT, RIGHT}
  - I2S_SLOT_BITS = 32
  - I2S_MAX_DATA_WIDTH = 32
  - typedef stereo_sample_t as a struct {left, right}
- Sub-module sync_edge_detect: one instance per input. Parameter SYNC_STAGES. Outputs the synchronized level and a registered rise pulse. For lrclk and sdata only the level is used, and the extra register stage keeps them aligned with the bclk rise pulse.

Test Plan:
- Reset and enable: rx_en=1, 64-bclk frames, left=24'hA5A5A5, right=24'h5A5A5A, ready=1 -> sample_data=48'hA5A5A5_5A5A5A; valid pulses once per frame; rx_locked high after the first left start.
- Mid-frame lock: enable while LRCLK=1 -> first delivered frame is the first complete left/right pair; no partial frame is emitted.
- Overrun: ready=0 for 3 frames -> first frame is held unchanged; overrun=1; status_clr -> overrun=0; ready=1 -> first frame is accepted.
- Simultaneous accept and new frame: ready pulsed exactly on the frame_done cycle -> new frame loaded, valid stays 1, overrun stays 0.
- Short and long slots: 16 bclk per half-frame with data 16'hFFFF -> left=24'hFFFF00 and short_word=1. 40 bclk per half-frame -> bits 25..40 ignored, data exact, short_word=0.
- Reset and disable mid-frame: assert board_aresetn low mid-word -> all outputs 0 immediately. Separately, drop rx_en mid-right-word -> no frame is emitted and the state returns to SYNC once re-enabled.

Source files
------------

// File: rtl/codec_pkg.sv
// Shared types and limits for the codec I2S record path.
package codec_pkg;

  localparam int unsigned I2S_SLOT_BITS      = 32;
  localparam int unsigned I2S_MAX_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LEFT,
    RIGHT
  } i2s_rx_state_t;

  typedef struct packed {
    logic [I2S_MAX_DATA_WIDTH-1:0] left;
    logic [I2S_MAX_DATA_WIDTH-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with a registered level and a registered rising-edge pulse.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;

  // level is the previous synchronized value, so rise and level stay cycle-aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      chain[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      level <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~level;
    end
  end

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S record-path deserializer: ADC serial stream to parallel {left, right} frames with valid/ready.
module i2s_rx_deserializer
  import codec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned SLOT_BITS   = I2S_SLOT_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    board_clk,
  input  logic                    board_aresetn,
  input  logic                    rx_en,
  input  logic                    i2s_bclk,
  input  logic                    i2s_lrclk,
  input  logic                    i2s_sdata,
  output logic [2*DATA_WIDTH-1:0] sample_data,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    rx_locked,
  output logic                    overrun,
  output logic                    short_word,
  input  logic                    status_clr
);

  localparam logic [5:0] DW_CNT   = 6'(DATA_WIDTH);
  localparam logic [5:0] SLOT_CNT = 6'(SLOT_BITS);

  logic bclk_rise, lr_now, sd_bit;
  logic bclk_level_unused, lr_rise_unused, sd_rise_unused;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk   (board_clk),
    .rst_n (board_aresetn),
    .d     (i2s_bclk),
    .level (bclk_level_unused),
    .rise  (bclk_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_lrclk_sync (
    .clk   (board_clk),
    .rst_n (board_aresetn),
    .d     (i2s_lrclk),
    .level (lr_now),
    .rise  (lr_rise_unused)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sdata_sync (
    .clk   (board_clk),
    .rst_n (board_aresetn),
    .d     (i2s_sdata),
    .level (sd_bit),
    .rise  (sd_rise_unused)
  );

  i2s_rx_state_t         state;
  logic [5:0]            count, count_inc, idx;
  logic                  lr_prev, transition, in_word, frame_done, short_evt;
  logic [DATA_WIDTH-1:0] left_sr, right_sr, left_word, cur_sr, cap_word;

  // cap_word is the current channel word with this rise's bit already placed,
  // so a closing transition can hand it straight to the word latch.
  always_comb begin
    transition = bclk_rise && (lr_now != lr_prev);
    count_inc  = (count >= SLOT_CNT) ? count : count + 6'd1;
    idx        = DW_CNT - 6'd1 - count;
    cur_sr     = (state == RIGHT) ? right_sr : left_sr;
    cap_word   = cur_sr;
    if (count < DW_CNT) begin
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
        if (idx == 6'(i)) cap_word[i] = sd_bit;
      end
    end
    in_word    = rx_en && ((state == LEFT) || (state == RIGHT));
    frame_done = rx_en && (state == RIGHT) && transition && !lr_now;
    short_evt  = in_word && transition && (count_inc < DW_CNT);
  end

  always_ff @(posedge board_clk or negedge board_aresetn) begin
    if (!board_aresetn) begin
      state     <= IDLE;
      count     <= '0;
      lr_prev   <= 1'b0;
      left_sr   <= '0;
      right_sr  <= '0;
      left_word <= '0;
      rx_locked <= 1'b0;
    end else begin
      if (bclk_rise) lr_prev <= lr_now;
      if (!rx_en) begin
        state     <= IDLE;
        count     <= '0;
        left_sr   <= '0;
        right_sr  <= '0;
        rx_locked <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            if (transition && !lr_now) begin
              state     <= LEFT;
              count     <= '0;
              left_sr   <= '0;
              right_sr  <= '0;
              rx_locked <= 1'b1;
            end
          end
          LEFT: begin
            if (transition && lr_now) begin
              left_word <= cap_word;
              left_sr   <= '0;
              count     <= '0;
              state     <= RIGHT;
            end else if (bclk_rise) begin
              left_sr <= cap_word;
              count   <= count_inc;
            end
          end
          RIGHT: begin
            if (transition && !lr_now) begin
              right_sr <= '0;
              count    <= '0;
              state    <= LEFT;
            end else if (bclk_rise) begin
              right_sr <= cap_word;
              count    <= count_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge board_clk or negedge board_aresetn) begin
    if (!board_aresetn) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      short_word   <= 1'b0;
    end else begin
      if (frame_done) begin
        if (!(sample_valid && !sample_ready)) begin
          sample_data  <= {left_word, cap_word};
          sample_valid <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      overrun    <= status_clr ? 1'b0 : (overrun | (frame_done && sample_valid && !sample_ready));
      short_word <= status_clr ? 1'b0 : (short_word | short_evt);
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for i2s_rx_deserializer: drives I2S frames and checks against a slot-level model.
module tb_i2s_rx_deserializer;

  localparam int unsigned DW = 24;

  logic          board_clk = 1'b0;
  logic          board_aresetn, rx_en, i2s_bclk, i2s_lrclk, i2s_sdata;
  logic          sample_ready, status_clr;
  logic [2*DW-1:0] sample_data;
  logic          sample_valid, rx_locked, overrun, short_word;

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  int unsigned   vcount = 0;
  logic          dly = 1'b0;
  logic [47:0]   got_q[$];
  logic [47:0]   exp_q[$];

  always #5 board_clk = ~board_clk;

  i2s_rx_deserializer #(.DATA_WIDTH(DW), .SLOT_BITS(32), .SYNC_STAGES(2)) dut (
    .board_clk     (board_clk),
    .board_aresetn (board_aresetn),
    .rx_en         (rx_en),
    .i2s_bclk      (i2s_bclk),
    .i2s_lrclk     (i2s_lrclk),
    .i2s_sdata     (i2s_sdata),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .rx_locked     (rx_locked),
    .overrun       (overrun),
    .short_word    (short_word),
    .status_clr    (status_clr)
  );

  always @(negedge board_clk) begin
    if (sample_valid) vcount++;
    if (sample_valid && sample_ready) got_q.push_back(sample_data);
  end

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Word as received: first min(L, DW) slot bits MSB-first, the rest zero.
  function automatic logic [DW-1:0] exp_word(input logic [63:0] slot, input int unsigned l);
    logic [DW-1:0] w;
    w = slot[63:40];
    if (l < DW) w = w & ~((24'd1 << (DW - l)) - 24'd1);
    return w;
  endfunction

  function automatic logic [47:0] exp_frame(input logic [63:0] ls, input logic [63:0] rs,
                                            input int unsigned l);
    return {exp_word(ls, l), exp_word(rs, l)};
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge board_clk);
    #1;
  endtask

  // One bclk period; data changes on the falling edge, one bit behind the slot (I2S delay).
  task automatic bperiod(input logic lr, input logic nb);
    i2s_bclk = 1'b0; i2s_lrclk = lr; i2s_sdata = dly; dly = nb;
    tick(4);
    i2s_bclk = 1'b1;
    tick(4);
  endtask

  task automatic send_slot(input logic lr, input logic [63:0] slot, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) bperiod(lr, slot[63-k]);
  endtask

  task automatic send_frame(input logic [63:0] ls, input logic [63:0] rs, input int unsigned l);
    send_slot(1'b0, ls, l);
    send_slot(1'b1, rs, l);
  endtask

  task automatic restart();
    rx_en = 1'b0; tick(3);
    rx_en = 1'b1; tick(3);
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1; tick(1);
    status_clr = 1'b0;
  endtask

  task automatic test_reset();
    tick(3);
    n_cmp++;
    if ({sample_valid, rx_locked, overrun, short_word} !== 4'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0000", {sample_valid, rx_locked, overrun, short_word});
    end
    n_cmp++;
    if (sample_data !== 48'h0) begin
      n_err++; $display("FAIL reset_data: got %h expected 0", sample_data);
    end
    board_aresetn = 1'b1;
    tick(4);
    n_cmp++;
    if (sample_valid !== 1'b0) begin
      n_err++; $display("FAIL idle_valid: got %b expected 0", sample_valid);
    end
  endtask

  task automatic test_basic();
    logic [63:0] r, ls, rs;
    sample_ready = 1'b1;
    restart();
    got_q.delete(); vcount = 0;
    n_cmp++;
    if (rx_locked !== 1'b0) begin
      n_err++; $display("FAIL basic_unlocked: got %b expected 0", rx_locked);
    end
    send_slot(1'b1, rnd64(), 32);
    for (int i = 0; i < 3; i++) begin
      r = rnd64(); ls = {24'hA5A5A5, r[39:0]};
      r = rnd64(); rs = {24'h5A5A5A, r[39:0]};
      send_frame(ls, rs, 32);
    end
    bperiod(1'b0, 1'b0);
    tick(2);
    n_cmp++;
    if (got_q.size() != 3) begin
      n_err++; $display("FAIL basic_count: got %0d expected 3", got_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== 48'hA5A5A5_5A5A5A) begin
        n_err++; $display("FAIL basic_data[%0d]: got %h expected a5a5a55a5a5a",
                          i, (i < got_q.size()) ? got_q[i] : 48'hx);
      end
    end
    n_cmp++;
    if (vcount != 3) begin
      n_err++; $display("FAIL basic_valid_pulses: got %0d expected 3", vcount);
    end
    n_cmp++;
    if (rx_locked !== 1'b1) begin
      n_err++; $display("FAIL basic_locked: got %b expected 1", rx_locked);
    end
  endtask

  task automatic test_random_frames();
    logic [63:0] ls, rs;
    sample_ready = 1'b1;
    restart();
    got_q.delete(); exp_q.delete();
    send_slot(1'b1, rnd64(), 32);
    for (int i = 0; i < 5; i++) begin
      ls = rnd64(); rs = rnd64();
      exp_q.push_back(exp_frame(ls, rs, 32));
      send_frame(ls, rs, 32);
    end
    bperiod(1'b0, 1'b0);
    tick(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL random_data[%0d]: got %h expected %h",
                          i, (i < got_q.size()) ? got_q[i] : 48'hx, exp_q[i]);
      end
    end
    n_cmp++;
    if ({overrun, short_word} !== 2'b00) begin
      n_err++; $display("FAIL random_flags: got %b expected 00", {overrun, short_word});
    end
  endtask

  task automatic test_mid_frame_lock();
    logic [63:0] ls, rs;
    sample_ready = 1'b1;
    rx_en = 1'b0; tick(3);
    got_q.delete(); exp_q.delete();
    send_slot(1'b0, rnd64(), 10);
    send_slot(1'b1, rnd64(), 12);
    rx_en = 1'b1; tick(4);
    send_slot(1'b1, rnd64(), 20);
    for (int i = 0; i < 2; i++) begin
      ls = rnd64(); rs = rnd64();
      exp_q.push_back(exp_frame(ls, rs, 32));
      send_frame(ls, rs, 32);
    end
    bperiod(1'b0, 1'b0);
    tick(2);
    n_cmp++;
    if (got_q.size() != 2) begin
      n_err++; $display("FAIL lock_count: got %0d expected 2", got_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL lock_data[%0d]: got %h expected %h",
                          i, (i < got_q.size()) ? got_q[i] : 48'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_overrun();
    logic [63:0] ls, rs;
    logic [47:0] first;
    sample_ready = 1'b0;
    restart();
    got_q.delete();
    send_slot(1'b1, rnd64(), 32);
    for (int i = 0; i < 3; i++) begin
      ls = rnd64(); rs = rnd64();
      if (i == 0) first = exp_frame(ls, rs, 32);
      send_frame(ls, rs, 32);
    end
    bperiod(1'b0, 1'b0);
    tick(2);
    n_cmp++;
    if (sample_valid !== 1'b1 || sample_data !== first) begin
      n_err++; $display("FAIL overrun_hold: got v=%b %h expected v=1 %h", sample_valid, sample_data, first);
    end
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++; $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    pulse_clr();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL overrun_clr: got %b expected 0", overrun);
    end
    sample_ready = 1'b1;
    tick(2);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== first) begin
      n_err++; $display("FAIL overrun_accept: got n=%0d %h expected n=1 %h",
                        got_q.size(), (got_q.size() > 0) ? got_q[0] : 48'hx, first);
    end
    n_cmp++;
    if (sample_valid !== 1'b0) begin
      n_err++; $display("FAIL overrun_drain: got %b expected 0", sample_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] la, ra, lb, rb;
    logic [47:0] fa, fb;
    sample_ready = 1'b0;
    restart();
    got_q.delete();
    send_slot(1'b1, rnd64(), 32);
    la = rnd64(); ra = rnd64(); lb = rnd64(); rb = rnd64();
    fa = exp_frame(la, ra, 32); fb = exp_frame(lb, rb, 32);
    send_frame(la, ra, 32);
    send_frame(lb, rb, 32);
    // Closing rise of frame B, with ready high only on the cycle frame B completes.
    i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_sdata = dly; dly = 1'b0;
    tick(4);
    i2s_bclk = 1'b1;
    tick(3);
    n_cmp++;
    if (sample_valid !== 1'b1 || sample_data !== fa) begin
      n_err++; $display("FAIL b2b_pending: got v=%b %h expected v=1 %h", sample_valid, sample_data, fa);
    end
    sample_ready = 1'b1;
    tick(1);
    sample_ready = 1'b0;
    n_cmp++;
    if (sample_valid !== 1'b1 || sample_data !== fb) begin
      n_err++; $display("FAIL b2b_load: got v=%b %h expected v=1 %h", sample_valid, sample_data, fb);
    end
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL b2b_overrun: got %b expected 0", overrun);
    end
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== fa) begin
      n_err++; $display("FAIL b2b_accept: got n=%0d expected n=1 %h", got_q.size(), fa);
    end
    tick(4);
  endtask

  task automatic test_short_long();
    logic [63:0] r, ls, rs;
    sample_ready = 1'b1;
    tick(2);
    pulse_clr();
    restart();
    got_q.delete(); exp_q.delete();
    send_slot(1'b1, rnd64(), 32);
    for (int i = 0; i < 2; i++) begin
      r = rnd64(); ls = {16'hFFFF, r[47:0]}; rs = rnd64();
      exp_q.push_back(exp_frame(ls, rs, 16));
      send_frame(ls, rs, 16);
    end
    bperiod(1'b0, 1'b0);
    tick(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || got_q[i][47:24] !== 24'hFFFF00) begin
        n_err++; $display("FAIL short_data[%0d]: got %h expected %h",
                          i, (i < got_q.size()) ? got_q[i] : 48'hx, exp_q[i]);
      end
    end
    n_cmp++;
    if (short_word !== 1'b1) begin
      n_err++; $display("FAIL short_set: got %b expected 1", short_word);
    end
    pulse_clr();
    n_cmp++;
    if (short_word !== 1'b0) begin
      n_err++; $display("FAIL short_clr: got %b expected 0", short_word);
    end
    restart();
    got_q.delete(); exp_q.delete();
    send_slot(1'b1, rnd64(), 40);
    for (int i = 0; i < 2; i++) begin
      ls = rnd64(); rs = rnd64();
      exp_q.push_back(exp_frame(ls, rs, 40));
      send_frame(ls, rs, 40);
    end
    bperiod(1'b0, 1'b0);
    tick(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL long_data[%0d]: got %h expected %h",
                          i, (i < got_q.size()) ? got_q[i] : 48'hx, exp_q[i]);
      end
    end
    n_cmp++;
    if (short_word !== 1'b0) begin
      n_err++; $display("FAIL long_short: got %b expected 0", short_word);
    end
  endtask

  task automatic test_disable_midframe();
    logic [63:0] la, ra, lb, rb, lc, rc, ld, rd;
    sample_ready = 1'b1;
    restart();
    got_q.delete(); exp_q.delete();
    send_slot(1'b1, rnd64(), 32);
    la = rnd64(); ra = rnd64(); lb = rnd64(); rb = rnd64();
    lc = rnd64(); rc = rnd64(); ld = rnd64(); rd = rnd64();
    exp_q.push_back(exp_frame(la, ra, 32));
    exp_q.push_back(exp_frame(ld, rd, 32));
    send_frame(la, ra, 32);
    send_slot(1'b0, lb, 32);
    send_slot(1'b1, rb, 10);
    rx_en = 1'b0; tick(2);
    send_slot(1'b1, rb << 10, 22);
    send_slot(1'b0, lc, 12);
    rx_en = 1'b1; tick(4);
    n_cmp++;
    if (rx_locked !== 1'b0) begin
      n_err++; $display("FAIL disable_resync: got %b expected 0", rx_locked);
    end
    send_slot(1'b0, lc << 12, 20);
    send_slot(1'b1, rc, 32);
    send_frame(ld, rd, 32);
    bperiod(1'b0, 1'b0);
    tick(2);
    n_cmp++;
    if (got_q.size() != 2) begin
      n_err++; $display("FAIL disable_count: got %0d expected 2", got_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL disable_data[%0d]: got %h expected %h",
                          i, (i < got_q.size()) ? got_q[i] : 48'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midword();
    sample_ready = 1'b0;
    restart();
    send_slot(1'b1, rnd64(), 32);
    send_frame(rnd64(), rnd64(), 32);
    send_slot(1'b0, rnd64(), 10);
    n_cmp++;
    if (sample_valid !== 1'b1 || rx_locked !== 1'b1) begin
      n_err++; $display("FAIL midreset_pre: got v=%b l=%b expected v=1 l=1", sample_valid, rx_locked);
    end
    board_aresetn = 1'b0;
    #1;
    n_cmp++;
    if ({sample_valid, rx_locked, overrun, short_word} !== 4'b0) begin
      n_err++; $display("FAIL midreset_flags: got %b expected 0000", {sample_valid, rx_locked, overrun, short_word});
    end
    n_cmp++;
    if (sample_data !== 48'h0) begin
      n_err++; $display("FAIL midreset_data: got %h expected 0", sample_data);
    end
    tick(2);
    board_aresetn = 1'b1;
    sample_ready = 1'b1;
    tick(2);
  endtask

  initial begin
    board_aresetn = 1'b0;
    rx_en         = 1'b0;
    i2s_bclk      = 1'b0;
    i2s_lrclk     = 1'b0;
    i2s_sdata     = 1'b0;
    sample_ready  = 1'b1;
    status_clr    = 1'b0;
    test_reset();
    test_basic();
    test_random_frames();
    test_mid_frame_lock();
    test_overrun();
    test_back_to_back();
    test_short_long();
    test_disable_midframe();
    test_reset_midword();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
